// File: rtl/reg_file_sb.sv
// Register file with two write lanes, two async read ports and a per-register pending bit.
// Define RF_BYPASS_EN to forward same-cycle write data/pending state onto the read ports.
module reg_file_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_busy_a,
  output logic                  rd_busy_b,
  input  logic                  wr_en0,
  input  logic [ADDR_WIDTH-1:0] wr_addr0,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic                  wr_en1,
  input  logic [ADDR_WIDTH-1:0] wr_addr1,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic                  claim_en,
  input  logic [ADDR_WIDTH-1:0] claim_addr,
  input  logic                  flush,
  output logic [REG_COUNT-1:0]  busy_vec
);

  logic [DATA_WIDTH-1:0] r_regs     [REG_COUNT];
  logic [REG_COUNT-1:0]  r_pend;

  logic [REG_COUNT-1:0]  w_hit0;
  logic [REG_COUNT-1:0]  w_hit1;
  logic [REG_COUNT-1:0]  w_claim_hit;
  logic [DATA_WIDTH-1:0] w_reg_nxt  [REG_COUNT];
  logic [REG_COUNT-1:0]  w_pend_nxt;
  logic [DATA_WIDTH-1:0] w_src_data [REG_COUNT];
  logic [REG_COUNT-1:0]  w_src_pend;

  // Address decode against each register index: out-of-range addresses match nothing.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      w_hit0[i]      = wr_en0   && (wr_addr0   == ADDR_WIDTH'(i));
      w_hit1[i]      = wr_en1   && (wr_addr1   == ADDR_WIDTH'(i));
      w_claim_hit[i] = claim_en && (claim_addr == ADDR_WIDTH'(i));

      w_reg_nxt[i] = r_regs[i];
      if (w_hit1[i]) begin
        w_reg_nxt[i] = wr_data1;
      end else if (w_hit0[i]) begin
        w_reg_nxt[i] = wr_data0;
      end

      w_pend_nxt[i] = r_pend[i];
      if (flush) begin
        w_pend_nxt[i] = 1'b0;
      end else if (w_claim_hit[i]) begin
        w_pend_nxt[i] = 1'b1;
      end else if (w_hit0[i] || w_hit1[i]) begin
        w_pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      r_regs <= w_reg_nxt;
      r_pend <= w_pend_nxt;
    end
  end

`ifdef RF_BYPASS_EN
  assign w_src_data = w_reg_nxt;
  assign w_src_pend = w_pend_nxt;
`else
  assign w_src_data = r_regs;
  assign w_src_pend = r_pend;
`endif

  always_comb begin
    rd_data_a = '0;
    rd_busy_a = 1'b0;
    rd_data_b = '0;
    rd_busy_b = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (rd_addr_a == ADDR_WIDTH'(i)) begin
        rd_data_a = w_src_data[i];
        rd_busy_a = w_src_pend[i];
      end
      if (rd_addr_b == ADDR_WIDTH'(i)) begin
        rd_data_b = w_src_data[i];
        rd_busy_b = w_src_pend[i];
      end
    end
  end

  assign busy_vec = r_pend;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: array/bit model checked every cycle plus literal pins.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        wr_en0, wr_en1;
  logic [3:0]  wr_addr0, wr_addr1;
  logic [15:0] wr_data0, wr_data1;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic        flush;
  logic [7:0]  busy_vec;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  logic [15:0] m_regs [8];
  logic [7:0]  m_pend;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_WIDTH(16), .REG_COUNT(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .flush(flush), .busy_vec(busy_vec)
  );

  function automatic logic [15:0] exp_data(logic [3:0] a);
    if (a >= 4'd8) return 16'h0;
`ifdef RF_BYPASS_EN
    if (wr_en1 && wr_addr1 == a) return wr_data1;
    if (wr_en0 && wr_addr0 == a) return wr_data0;
`endif
    return m_regs[a[2:0]];
  endfunction

  function automatic logic exp_busy(logic [3:0] a);
    if (a >= 4'd8) return 1'b0;
`ifdef RF_BYPASS_EN
    if (flush) return 1'b0;
    if (claim_en && claim_addr == a) return 1'b1;
    if ((wr_en0 && wr_addr0 == a) || (wr_en1 && wr_addr1 == a)) return 1'b0;
`endif
    return m_pend[a[2:0]];
  endfunction

  // Model: apply lane 0 then lane 1 (later write wins), clear pending on writes, then claim.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_pend = 8'h0;
    end else begin
      if (wr_en0 && wr_addr0 < 4'd8) m_regs[wr_addr0[2:0]] = wr_data0;
      if (wr_en1 && wr_addr1 < 4'd8) m_regs[wr_addr1[2:0]] = wr_data1;
      if (flush) begin
        m_pend = 8'h0;
      end else begin
        if (wr_en0 && wr_addr0 < 4'd8) m_pend[wr_addr0[2:0]] = 1'b0;
        if (wr_en1 && wr_addr1 < 4'd8) m_pend[wr_addr1[2:0]] = 1'b0;
        if (claim_en && claim_addr < 4'd8) m_pend[claim_addr[2:0]] = 1'b1;
      end
    end
  end

  task automatic pin(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      pin("rd_data_a", 32'(rd_data_a), 32'(exp_data(rd_addr_a)));
      pin("rd_data_b", 32'(rd_data_b), 32'(exp_data(rd_addr_b)));
      pin("rd_busy_a", 32'(rd_busy_a), 32'(exp_busy(rd_addr_a)));
      pin("rd_busy_b", 32'(rd_busy_b), 32'(exp_busy(rd_addr_b)));
      pin("busy_vec",  32'(busy_vec),  32'(m_pend));
    end
  end

  task automatic idle();
    rst = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; claim_en = 1'b0; flush = 1'b0;
    wr_addr0 = 4'h0; wr_addr1 = 4'h0; wr_data0 = 16'h0; wr_data1 = 16'h0;
    claim_addr = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd0;
    wr_en0 = 1'b1; wr_addr0 = 4'd3; wr_data0 = 16'hBEEF;
    tick();
    chk_en = 1'b1;
    tick();
    idle(); rd_addr_a = 4'd3; #1;
    pin("reset_busy_vec", 32'(busy_vec), 32'h0);
    pin("reset_reg3", 32'(rd_data_a), 32'h0);
    pin("reset_busy3", 32'(rd_busy_a), 32'h0);
    tick();

    // Dual write to the same register: lane 1 wins
    wr_en0 = 1'b1; wr_addr0 = 4'd5; wr_data0 = 16'h1111;
    wr_en1 = 1'b1; wr_addr1 = 4'd5; wr_data1 = 16'h2222;
    tick();
    idle(); rd_addr_a = 4'd5; #1;
    pin("dual_write_reg5", 32'(rd_data_a), 32'h2222);
    tick();

    // Claim then retire
    claim_en = 1'b1; claim_addr = 4'd2;
    tick();
    idle(); rd_addr_a = 4'd2; #1;
    pin("claim_busy_vec", 32'(busy_vec), 32'h04);
    pin("claim_rd_busy_a", 32'(rd_busy_a), 32'h1);
    wr_en1 = 1'b1; wr_addr1 = 4'd2; wr_data1 = 16'h00AA;
    tick();
    idle(); rd_addr_a = 4'd2; #1;
    pin("retire_busy_vec", 32'(busy_vec), 32'h0);
    pin("retire_reg2", 32'(rd_data_a), 32'h00AA);

    // Claim and write collide, then flush overrides a claim
    claim_en = 1'b1; claim_addr = 4'd6;
    wr_en0 = 1'b1; wr_addr0 = 4'd6; wr_data0 = 16'h1234;
    tick();
    idle(); rd_addr_b = 4'd6; #1;
    pin("collide_reg6", 32'(rd_data_b), 32'h1234);
    pin("collide_busy_vec", 32'(busy_vec), 32'h40);
    flush = 1'b1; claim_en = 1'b1; claim_addr = 4'd1;
    tick();
    idle(); #1;
    pin("flush_busy_vec", 32'(busy_vec), 32'h0);

    // Out-of-range write and claim
    wr_en0 = 1'b1; wr_addr0 = 4'hC; wr_data0 = 16'hFFFF;
    claim_en = 1'b1; claim_addr = 4'hC; rd_addr_a = 4'hC;
    tick();
    idle(); rd_addr_a = 4'hC; #1;
    pin("oor_busy_vec", 32'(busy_vec), 32'h0);
    pin("oor_rd_data", 32'(rd_data_a), 32'h0);
    pin("oor_rd_busy", 32'(rd_busy_a), 32'h0);
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a);
      tick();
    end

    // Same-cycle write and read of register 1 (previously 0)
    wr_en0 = 1'b1; wr_addr0 = 4'd1; wr_data0 = 16'h0F0F; rd_addr_a = 4'd1; #1;
`ifdef RF_BYPASS_EN
    pin("bypass_reg1", 32'(rd_data_a), 32'h0F0F);
`else
    pin("bypass_reg1", 32'(rd_data_a), 32'h0);
`endif
    tick();
    idle(); #1;
    pin("after_write_reg1", 32'(rd_data_a), 32'h0F0F);

    // Mixed traffic, checked cycle by cycle against the model
    for (int n = 0; n < 80; n++) begin
      rst        = ($urandom_range(0, 29) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      wr_en0     = 1'($urandom_range(0, 1));
      wr_en1     = 1'($urandom_range(0, 1));
      claim_en   = 1'($urandom_range(0, 1));
      wr_addr0   = 4'($urandom_range(0, 11));
      wr_addr1   = 4'($urandom_range(0, 11));
      claim_addr = 4'($urandom_range(0, 11));
      wr_data0   = 16'($urandom);
      wr_data1   = 16'($urandom);
      rd_addr_a  = 4'($urandom_range(0, 15));
      rd_addr_b  = 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
